// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning HI/LO; shift-add multiply, restoring divide.
// Latency: start edge t0 -> done pulse and HI/LO valid after edge t0+WIDTH+1.
// Backpressure: busy high for WIDTH+1 cycles; start and MTHI/MTLO are dropped while busy.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q;
  logic               is_div_q, neg_q_q, neg_r_q, dz_q;
  logic [WIDTH-1:0]   opb_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;

  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH-1:0]   div_sub;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    a_abs = (op[0] && srca[WIDTH-1]) ? -srca : srca;
    b_abs = (op[0] && srcb[WIDTH-1]) ? -srcb : srcb;

    // Multiply: acc = {partial product, remaining multiplier bits}; opb holds |multiplicand|.
    mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
              (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});

    // Divide: acc low half shifts the dividend out and the quotient in; opb holds |divisor|.
    div_shift = {rem_q, acc_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, opb_q};
    div_sub   = div_shift[WIDTH-1:0] - opb_q;

    prod_fix = neg_q_q ? -acc_q : acc_q;
    // A zero divisor leaves |srca| in the remainder, so the usual sign fix restores raw srca.
    quo_fix  = dz_q ? {WIDTH{1'b1}}
                    : (neg_q_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
    rem_fix  = neg_r_q ? -rem_q : rem_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == CW'(WIDTH-1)) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      dz_q     <= 1'b0;
      opb_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (wr_hi) hi_q <= wdata;
          if (wr_lo) lo_q <= wdata;
          if (start) begin
            cnt_q    <= '0;
            is_div_q <= op[1];
            neg_q_q  <= op[0] & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
            neg_r_q  <= op[0] & srca[WIDTH-1];
            dz_q     <= op[1] & (srcb == '0);
            rem_q    <= '0;
            if (op[1]) begin
              acc_q <= {{WIDTH{1'b0}}, a_abs};
              opb_q <= b_abs;
            end else begin
              acc_q <= {{WIDTH{1'b0}}, b_abs};
              opb_q <= a_abs;
            end
          end
        end
        RUN: begin
          cnt_q <= cnt_q + 1'b1;
          if (is_div_q) begin
            rem_q             <= div_ge ? div_sub : div_shift[WIDTH-1:0];
            acc_q[WIDTH-1:0]  <= {acc_q[WIDTH-2:0], div_ge};
          end else begin
            acc_q <= {mul_sum, acc_q[WIDTH-1:1]};
          end
        end
        FINISH: begin
          if (is_div_q) begin
            hi_q <= rem_fix;
            lo_q <= quo_fix;
          end else begin
            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, busy window, sign rules, divide corner cases,
// ignored start/MTHI while busy, MTLO in idle and asynchronous abort.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] srca, srcb;
  logic        wr_hi, wr_lo;
  logic [31:0] wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_chk  = 0;
  int n_pass = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .srca  (srca),
    .srcb  (srcb),
    .wr_hi (wr_hi),
    .wr_lo (wr_lo),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Launch one op and watch 80 cycles. s2_k / wh_k: cycle (after t0) at which a stray
  // start / MTHI is driven, 0 = none. wr_start: MTHI of 0x5555 on the start edge itself.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input int s2_k, input int wh_k, input bit wr_start);
    int busy_cnt, done_cnt, done_k;
    bit prev_done, twice;
    logic [31:0] hi0;
    @(negedge clk);
    op = o; srca = a; srcb = b; start = 1'b1;
    if (wr_start) begin wr_hi = 1'b1; wdata = 32'h5555; end
    @(posedge clk); #1;
    start = 1'b0; wr_hi = 1'b0;
    srca = 32'hDEAD_BEEF; srcb = 32'h0BAD_F00D;
    if (wr_start) chk({tag, " mthi_on_start"}, {32'h0, hi}, 64'h5555);
    hi0 = hi;
    busy_cnt = busy ? 1 : 0;
    done_cnt = 0; done_k = 0; prev_done = 1'b0; twice = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      if (k == s2_k) begin start = 1'b1; op = 2'b00; srca = 32'd5; srcb = 32'd9; end
      if (k == wh_k) begin wr_hi = 1'b1; wdata = 32'h1234; end
      @(posedge clk); #1;
      start = 1'b0; wr_hi = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_k == 0) done_k = k;
        if (prev_done) twice = 1'b1;
      end
      prev_done = done;
      if (wh_k != 0 && k == wh_k + 1) chk({tag, " hi_stable_run"}, {32'h0, hi}, {32'h0, hi0});
    end
    chk({tag, " latency"},  64'(done_k),   64'd33);
    chk({tag, " busy_cyc"}, 64'(busy_cnt), 64'd33);
    chk({tag, " done_cnt"}, 64'(done_cnt), 64'd1);
    chk({tag, " done_2row"}, {63'h0, twice}, 64'd0);
    chk({tag, " hi"}, {32'h0, hi}, {32'h0, ehi});
    chk({tag, " lo"}, {32'h0, lo}, {32'h0, elo});
  endtask

  initial begin
    int dn;
    reset = 1'b0; start = 1'b0; op = 2'b00; srca = '0; srcb = '0;
    wr_hi = 1'b0; wr_lo = 1'b0; wdata = '0;
    #1;
    chk("rst busy", {63'h0, busy}, 64'd0);
    chk("rst done", {63'h0, done}, 64'd0);
    chk("rst hi",   {32'h0, hi},   64'd0);
    chk("rst lo",   {32'h0, lo},   64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;

    run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 0, 0, 1'b0);
    run_op("mult_m3x7", 2'b01, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 0, 0, 1'b0);
    run_op("div_m7d2",  2'b11, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 0, 0, 1'b0);
    run_op("divu_dz",   2'b10, 32'd100,       32'd0,         32'h0000_0064, 32'hFFFF_FFFF, 0, 0, 1'b0);
    run_op("div_ovf",   2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 0, 0, 1'b0);
    run_op("divu_10d3", 2'b10, 32'd10,        32'd3,         32'h0000_0001, 32'h0000_0003, 5, 10, 1'b0);

    @(negedge clk); wr_lo = 1'b1; wdata = 32'h0000_ABCD;
    @(posedge clk); #1; wr_lo = 1'b0;
    chk("mtlo lo", {32'h0, lo}, 64'hABCD);
    chk("mtlo hi_keep", {32'h0, hi}, 64'h1);

    @(negedge clk); op = 2'b00; srca = 32'hFFFF_FFFF; srcb = 32'hFFFF_FFFF; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (12) @(posedge clk);
    #1; reset = 1'b0; #1;
    chk("abort busy", {63'h0, busy}, 64'd0);
    chk("abort done", {63'h0, done}, 64'd0);
    chk("abort hi",   {32'h0, hi},   64'd0);
    chk("abort lo",   {32'h0, lo},   64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b1;
    dn = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dn++;
    end
    chk("abort no_done", 64'(dn), 64'd0);

    run_op("multu_6x7", 2'b00, 32'd6, 32'd7, 32'h0000_0000, 32'h0000_002A, 0, 0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
